// File: rtl/jogo_desafio_memoria_pkg.sv
// Shared definitions for the memory challenge game: FSM state codes, the two
// sequence ROMs, timing constants and the round limits for each game length.
package jogo_desafio_memoria_pkg;

    // FSM state codes. These values are also what db_estado displays.
    typedef enum logic [3:0] {
        S_INICIAL        = 4'h0,
        S_PREPARACAO     = 4'h1,
        S_MOSTRA         = 4'h2,
        S_APAGA          = 4'h3,
        S_ESPERA         = 4'h4,
        S_REGISTRA       = 4'h5,
        S_COMPARA        = 4'h6,
        S_PROXIMA        = 4'h7,
        S_ULTIMA_RODADA  = 4'h8,
        S_PROXIMA_RODADA = 4'h9,
        S_GANHOU         = 4'hA,
        S_PERDEU         = 4'hB,
        S_TIMEOUT        = 4'hC
    } estado_t;

    // Timing in clock cycles (1 kHz clock: 0.5 s lit, 0.5 s dark, 5 s to answer).
    localparam int T_MOSTRA = 500;
    localparam int T_APAGA  = 500;
    localparam int T_ESPERA = 5000;
    localparam int TIMER_W  = 13;

    // Terminal values of the shared timer in each timed state.
    localparam logic [TIMER_W-1:0] MOSTRA_FIM = TIMER_W'(T_MOSTRA - 1);
    localparam logic [TIMER_W-1:0] APAGA_FIM  = TIMER_W'(T_APAGA - 1);
    localparam logic [TIMER_W-1:0] ESPERA_FIM = TIMER_W'(T_ESPERA - 1);

    // Round limit value of the final round: 8 rounds (nivel 0) or 16 (nivel 1).
    localparam logic [3:0] LIMITE_NIVEL0 = 4'd7;
    localparam logic [3:0] LIMITE_NIVEL1 = 4'd15;

    // Sequence ROMs, word 0 in the least significant nibble.
    // ROM0: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4
    // ROM1: 1,1,1,1,2,2,2,2,4,4,4,4,8,8,8,8
    localparam logic [63:0] ROM0 = 64'h4188_4422_1124_8421;
    localparam logic [63:0] ROM1 = 64'h8888_4444_2222_1111;

    function automatic logic [3:0] rom_word(input logic sel, input logic [3:0] addr);
        logic [5:0] base;
        base = {addr, 2'b00};
        return sel ? ROM1[base +: 4] : ROM0[base +: 4];
    endfunction

    function automatic logic [3:0] limite_final(input logic niv);
        return niv ? LIMITE_NIVEL1 : LIMITE_NIVEL0;
    endfunction

endpackage

// File: rtl/jogo_desafio_memoria_hexa7seg.sv
// Hex digit to 7-segment image, active-low, segment order gfedcba.
module hexa7seg (
    input  logic [3:0] valor,
    output logic [6:0] seg
);

    // Pure lookup from nibble to segment pattern.
    always_comb begin
        unique case (valor)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/jogo_desafio_memoria_top.sv
// Memory challenge game: shows a growing sequence of ROM words on the leds and
// checks the player's button presses against it, one more word per round.
module jogo_desafio_memoria_top
    import jogo_desafio_memoria_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    input  logic       nivel,
    input  logic       memoria,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_clock,
    output logic       db_tem_jogada,
    output logic       db_chavesIgualMemoria,
    output logic       db_enderecoIgualSequencia,
    output logic       db_fimS,
    output logic       db_timeout,
    output logic       db_timeoutL,
    output logic       db_seletor_memoria,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_sequencia,
    output logic [6:0] db_estado
);

    estado_t              estado;
    logic [3:0]           endereco;
    logic [3:0]           limite;
    logic [3:0]           jogada;
    logic [TIMER_W-1:0]   timer;
    logic                 nivel_r;
    logic                 memoria_r;
    logic                 botoes_prev;

    logic [3:0]           rom_atual;
    logic                 tem_jogada;
    logic                 jogada_nova;

    assign rom_atual   = rom_word(memoria_r, endereco);
    assign tem_jogada  = |botoes;
    // A press counts only on the rising edge of "any button", so a held
    // button is accepted once and must be released before the next press.
    assign jogada_nova = tem_jogada & ~botoes_prev;

    // Game FSM plus its datapath (address, round limit, timer, button register).
    // NOTE: asynchronous reset clears every register here; the ROMs are
    // constants, so there is no memory array that would need a reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= S_INICIAL;
            endereco    <= '0;
            limite      <= '0;
            jogada      <= '0;
            timer       <= '0;
            nivel_r     <= 1'b0;
            memoria_r   <= 1'b0;
            botoes_prev <= 1'b0;
            ganhou      <= 1'b0;
            perdeu      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the register values from before this edge.
            botoes_prev <= tem_jogada;
            unique case (estado)
                S_INICIAL, S_GANHOU, S_PERDEU, S_TIMEOUT: begin
                    if (jogar) estado <= S_PREPARACAO;
                end
                S_PREPARACAO: begin
                    endereco  <= '0;
                    limite    <= '0;
                    jogada    <= '0;
                    timer     <= '0;
                    ganhou    <= 1'b0;
                    perdeu    <= 1'b0;
                    timeout   <= 1'b0;
                    nivel_r   <= nivel;
                    memoria_r <= memoria;
                    estado    <= S_MOSTRA;
                end
                S_MOSTRA: begin
                    if (timer == MOSTRA_FIM) begin
                        timer  <= '0;
                        estado <= S_APAGA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_APAGA: begin
                    if (timer == APAGA_FIM) begin
                        timer <= '0;
                        if (endereco < limite) begin
                            endereco <= endereco + 4'd1;
                            estado   <= S_MOSTRA;
                        end else begin
                            endereco <= '0;
                            estado   <= S_ESPERA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ESPERA: begin
                    if (jogada_nova) begin
                        jogada <= botoes;
                        estado <= S_REGISTRA;
                    end else if (timer == ESPERA_FIM) begin
                        timeout <= 1'b1;
                        estado  <= S_TIMEOUT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_REGISTRA: begin
                    estado <= S_COMPARA;
                end
                S_COMPARA: begin
                    if (jogada == rom_atual) begin
                        estado <= (endereco < limite) ? S_PROXIMA : S_ULTIMA_RODADA;
                    end else begin
                        perdeu <= 1'b1;
                        estado <= S_PERDEU;
                    end
                end
                S_PROXIMA: begin
                    endereco <= endereco + 4'd1;
                    timer    <= '0;
                    estado   <= S_ESPERA;
                end
                S_ULTIMA_RODADA: begin
                    if (limite == limite_final(nivel_r)) begin
                        ganhou <= 1'b1;
                        estado <= S_GANHOU;
                    end else begin
                        estado <= S_PROXIMA_RODADA;
                    end
                end
                S_PROXIMA_RODADA: begin
                    limite   <= limite + 4'd1;
                    endereco <= '0;
                    timer    <= '0;
                    estado   <= S_MOSTRA;
                end
                default: estado <= S_INICIAL;
            endcase
        end
    end

    // Led mux: ROM word while showing, live buttons while waiting for input.
    always_comb begin
        leds = 4'b0000;
        if (estado == S_MOSTRA) leds = rom_atual;
        else if (estado == S_ESPERA || estado == S_REGISTRA) leds = botoes;
    end

    assign pronto                    = (estado == S_GANHOU) || (estado == S_PERDEU) ||
                                       (estado == S_TIMEOUT);
    assign db_clock                  = clock;
    assign db_tem_jogada             = tem_jogada;
    assign db_chavesIgualMemoria     = (jogada == rom_atual);
    assign db_enderecoIgualSequencia = (endereco == limite);
    assign db_fimS                   = (limite == limite_final(nivel_r));
    assign db_timeout                = (estado == S_ESPERA) && (timer == ESPERA_FIM);
    assign db_timeoutL               = ((estado == S_MOSTRA) || (estado == S_APAGA)) &&
                                       (timer == MOSTRA_FIM);
    assign db_seletor_memoria        = memoria_r;

    hexa7seg u_hex_contagem   (.valor(endereco),  .seg(db_contagem));
    hexa7seg u_hex_memoria    (.valor(rom_atual), .seg(db_memoria));
    hexa7seg u_hex_jogada     (.valor(jogada),    .seg(db_jogadafeita));
    hexa7seg u_hex_sequencia  (.valor(limite),    .seg(db_sequencia));
    hexa7seg u_hex_estado     (.valor(estado),    .seg(db_estado));

endmodule

// File: tb/tb_jogo_desafio_memoria_top.sv
// Self-checking bench for jogo_desafio_memoria_top: plays whole games at the
// level of rounds and presses, with expectations taken from the game rules.
module tb_jogo_desafio_memoria_top;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic       nivel = 1'b0;
    logic       memoria = 1'b0;

    logic       ganhou, perdeu, timeout, pronto;
    logic [3:0] leds;
    logic       db_clock, db_tem_jogada, db_chavesIgualMemoria, db_enderecoIgualSequencia;
    logic       db_fimS, db_timeout, db_timeoutL, db_seletor_memoria;
    logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_sequencia, db_estado;

    jogo_desafio_memoria_top dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
        .nivel(nivel), .memoria(memoria),
        .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto),
        .leds(leds), .db_clock(db_clock), .db_tem_jogada(db_tem_jogada),
        .db_chavesIgualMemoria(db_chavesIgualMemoria),
        .db_enderecoIgualSequencia(db_enderecoIgualSequencia),
        .db_fimS(db_fimS), .db_timeout(db_timeout), .db_timeoutL(db_timeoutL),
        .db_seletor_memoria(db_seletor_memoria),
        .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_jogadafeita(db_jogadafeita), .db_sequencia(db_sequencia),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] rom0 [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                              4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};
    logic [3:0] rom1 [16] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
                              4'd4, 4'd4, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd8};

    // Active-low gfedcba images of hex digits.
    function automatic logic [6:0] img(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] rom(input bit m, input int a);
        return m ? rom1[a & 15] : rom0[a & 15];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Waits (bounded) until db_estado shows the given state code.
    task automatic wait_state(input logic [3:0] code, input int budget, input string tag,
                              output int cyc);
        cyc = 0;
        while (db_estado !== img(code) && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_reach"}, db_estado, img(code));
    endtask

    task automatic check_result(input string tag, input bit g, input bit p, input bit t);
        check({tag, "_ganhou"}, ganhou, g);
        check({tag, "_perdeu"}, perdeu, p);
        check({tag, "_timeout"}, timeout, t);
        check({tag, "_pronto"}, pronto, g | p | t);
    endtask

    // Plays one game. fail_round/fail_pos/fail_btn plant one wrong press
    // (fail_round 0 = none); to_round > 0 leaves that round unanswered.
    task automatic play_game(input string tag, input bit mem, input bit niv,
                             input int fail_round, input int fail_pos, input logic [3:0] fail_btn,
                             input int to_round, input bit toggle);
        int         rounds;
        int         cyc;
        int         guard;
        int         words;
        int         hold;
        int         dummy;
        logic [6:0] st;
        logic [6:0] prev;
        logic [3:0] btn;

        rounds = niv ? 16 : 8;
        @(negedge clock);
        memoria = mem;
        nivel   = niv;
        jogar   = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        cyc   = 1;

        for (int r = 1; r <= rounds; r++) begin
            if (toggle) begin
                memoria = 1'($urandom_range(0, 1));
                nivel   = 1'($urandom_range(0, 1));
            end
            words = 0;
            guard = 0;
            prev  = 7'h7F;
            st    = db_estado;
            while (guard < r * 1000 + 100) begin
                st = db_estado;
                if (st == img(4'h2) && prev != img(4'h2)) begin
                    check({tag, "_leds_show"}, leds, rom(mem, words));
                    words++;
                end
                if (st == img(4'h3) && prev == img(4'h2))
                    check({tag, "_leds_dark"}, leds, 4'b0000);
                if (st == img(4'h4)) break;
                prev = st;
                @(negedge clock);
                cyc++;
                guard++;
            end
            check({tag, "_espera_reach"}, db_estado, img(4'h4));
            check({tag, "_round_words"}, words, r);
            check({tag, "_sel_mem"}, db_seletor_memoria, mem);
            if (r == 1) begin
                check({tag, "_first_espera_time"}, (cyc >= 990 && cyc <= 1010), 1'b1);
                check_result({tag, "_cleared"}, 1'b0, 1'b0, 1'b0);
            end

            if (r == to_round) begin
                wait_state(4'hC, 5100, {tag, "_timeout"}, cyc);
                check({tag, "_timeout_time"}, (cyc >= 4995 && cyc <= 5005), 1'b1);
                check_result({tag, "_to"}, 1'b0, 1'b0, 1'b1);
                return;
            end

            for (int p = 0; p < r; p++) begin
                wait_state(4'h4, 20, {tag, "_espera"}, dummy);
                btn = (r == fail_round && p == fail_pos) ? fail_btn : rom(mem, p);
                botoes = btn;
                #1;
                check({tag, "_leds_in"}, leds, btn);
                check({tag, "_tem_jogada"}, db_tem_jogada, 1'b1);
                hold = (toggle && $urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                            : $urandom_range(1, 3);
                repeat (hold) @(negedge clock);
                botoes = 4'b0000;
                @(negedge clock);
                if (r == fail_round && p == fail_pos) begin
                    wait_state(4'hB, 20, {tag, "_perdeu"}, dummy);
                    check_result({tag, "_lost"}, 1'b0, 1'b1, 1'b0);
                    return;
                end
            end

            if (r == rounds) begin
                wait_state(4'hA, 20, {tag, "_ganhou"}, dummy);
                check_result({tag, "_won"}, 1'b1, 1'b0, 1'b0);
                return;
            end
        end
    endtask

    initial begin
        int         fr;
        int         fp;
        logic [3:0] fb;
        logic [3:0] expw;
        bit         rm;

        // Reset held low, even with jogar asserted.
        jogar = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_estado", db_estado, img(4'h0));
        check("rst_leds", leds, 4'b0000);
        check_result("rst", 1'b0, 1'b0, 1'b0);
        check("rst_contagem", db_contagem, img(4'h0));
        check("rst_sequencia", db_sequencia, img(4'h0));
        check("rst_jogadafeita", db_jogadafeita, img(4'h0));
        check("rst_sel_mem", db_seletor_memoria, 1'b0);
        jogar = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("idle_estado", db_estado, img(4'h0));

        // ROM0, 16 rounds: rounds 1-3 correct, round 4 presses 1,2,2 -> loss.
        play_game("rom0_loss", 1'b0, 1'b1, 4, 2, 4'b0010, 0, 1'b0);
        repeat (50) @(negedge clock);
        check("loss_held", perdeu, 1'b1);
        check("loss_estado", db_estado, img(4'hB));

        // ROM1 restart from perdeu: round 2 presses 1,4 -> loss.
        play_game("rom1_loss", 1'b1, 1'b0, 2, 1, 4'b0100, 0, 1'b0);

        // No answer in round 1 -> timeout.
        play_game("timeout", 1'($urandom_range(0, 1)), 1'b0, 0, 0, 4'b0000, 1, 1'b0);

        // Full 8-round game with memoria/nivel toggled during play.
        play_game("win8", 1'($urandom_range(0, 1)), 1'b0, 0, 0, 4'b0000, 0, 1'b1);

        // Random short loss.
        rm   = 1'($urandom_range(0, 1));
        fr   = $urandom_range(1, 3);
        fp   = $urandom_range(0, fr - 1);
        expw = rom(rm, fp);
        do fb = 4'b0001 << $urandom_range(0, 3); while (fb == expw);
        play_game("rand_loss", rm, 1'($urandom_range(0, 1)), fr, fp, fb, 0, 1'b0);

        // Random timeout in round 2.
        play_game("rand_to", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 4'b0000,
                  2, 1'b0);

        // Reset mid-game aborts with no result.
        @(negedge clock);
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        repeat ($urandom_range(100, 400)) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_estado", db_estado, img(4'h0));
        check("midrst_leds", leds, 4'b0000);
        check_result("midrst", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("after_rst_estado", db_estado, img(4'h0));
        check_result("after_rst", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jogo_desafio_memoria_top.md
JOGO_DESAFIO_MEMORIA_TOP -- requirements
Module: jogo_desafio_memoria_top

Interface
REQ-001 clock  in  1  system clock; all state changes on its rising edge; nominal 1 kHz.
REQ-002 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-003 jogar  in  1  starts a game when sampled high in the initial or any final state.
REQ-004 botoes  in  4  player buttons, one-hot when pressed, 0000 when idle.
REQ-005 nivel  in  1  game length, latched at game start: 0 = 8 rounds, 1 = 16 rounds.
REQ-006 memoria  in  1  sequence ROM select, latched at game start: 0 = ROM0, 1 = ROM1.
REQ-007 ganhou, perdeu, timeout  out  1 each  game result flags, held until the next game starts.
REQ-008 pronto  out  1  high in any final state (win, loss or timeout).
REQ-009 leds  out  4  shows the current ROM word during display; shows botoes during input; otherwise 0000.
REQ-010 db_clock, db_tem_jogada, db_chavesIgualMemoria, db_enderecoIgualSequencia, db_fimS, db_timeout, db_timeoutL, db_seletor_memoria  out  1 each  debug flags (clock copy, |botoes, button register equals ROM word, address equals round limit, last round reached, input timeout tick, display timer tick, latched memoria).
REQ-011 db_contagem, db_memoria, db_jogadafeita, db_sequencia, db_estado  out  7 each  hex 7-segment images of address, ROM word, button register, round limit and FSM state code.

Function
REQ-012 ROM0 words 0..15 SHALL be 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (binary one-hot).
REQ-013 ROM1 words 0..15 SHALL be 1,1,1,1,2,2,2,2,4,4,4,4,8,8,8,8.
REQ-014 FSM states and 4-bit codes: inicial 0, preparacao 1, mostra 2, apaga 3, espera 4, registra 5, compara 6, proxima 7, ultima_rodada 8, proxima_rodada 9, ganhou A, perdeu B, timeout C.
REQ-015 inicial --jogar--> preparacao; preparacao clears all counters, flags and the button register, latches nivel and memoria, sets round limit to 0, then moves to mostra.
REQ-016 mostra: leds = ROM[address] for 500 cycles, then apaga.
REQ-017 apaga: leds = 0000 for 500 cycles, so each word takes 1000 cycles in total.
REQ-018 From apaga, if address < round limit, increment address and return to mostra; otherwise clear address and go to espera.
REQ-019 espera: when |botoes rises (edge detected), go to registra and store botoes into the button register; the 5000-cycle input timer SHALL restart on each entry into espera.
REQ-020 If the input timer expires in espera, go to state timeout with timeout=1.
REQ-021 compara: on mismatch go to perdeu (perdeu=1).
REQ-022 compara on match: if address < round limit, go to proxima (increment address) and then espera; else go to ultima_rodada.
REQ-023 ultima_rodada: if round limit = 7 (nivel 0) or 15 (nivel 1), go to ganhou (ganhou=1); else go to proxima_rodada.
REQ-024 proxima_rodada: increment round limit, clear address, return to mostra.
REQ-025 A button must return to 0000 before the next jogada is accepted; a held button counts once.
REQ-026 From ganhou, perdeu or timeout, jogar restarts at preparacao; memoria and nivel are re-latched; changes to them during a game SHALL have no effect.
REQ-027 Counters are 4-bit, no wrap is reachable; 7-seg encoding SHALL be active-low, segment order gfedcba, hex 0-F.

Reset
REQ-028 reset low SHALL immediately force state inicial, all counters and registers to 0, all result flags and pronto to 0, and leds to 0000.
REQ-029 Reset mid-game SHALL abort the game with no result flag asserted.
REQ-030 db_estado SHALL show the image of 0 during and after reset.

Structure
REQ-031 State codes, ROM contents, timing constants (500, 5000) and round limits (7, 15) SHALL live in a shared package.
REQ-032 The 7-segment decoder SHALL be one sub-module, hexa7seg, instantiated five times; the datapath and FSM SHALL stay in this module.

Verification
REQ-033 reset pulse -> state 0, all outputs 0, leds 0000.
REQ-034 memoria=0, nivel=1, jogar -> leds show 0001 for 500 cycles; espera entered at about 1000 cycles; pressing 0001 advances to round 2.
REQ-035 ROM0: correctly play rounds 1-3, then in round 4 press 0001, 0010, 0010 -> perdeu=1, pronto=1, db_estado image B.
REQ-036 memoria=1 with jogar -> ROM1; round 1 press 0001 passes; round 2 press 0001, 0100 -> perdeu=1.
REQ-037 Toggle memoria between rounds -> the sequence remains unchanged.
REQ-038 No press for 5000 cycles in espera -> timeout=1 and state C; a full correct 8-round game at nivel 0 -> ganhou=1.
